// File: rtl/async_fifo_rd_burst.sv
// async_fifo_rd_burst: drains a FIFO in threshold/timeout bursts onto a registered valid/ready stream
module async_fifo_rd_burst #(
  parameter int W = 8,
  parameter int DP = 4,
  parameter int BURST = 4,
  parameter int TMO = 16,
  parameter int TW = 5,
  localparam int AW = $clog2(DP)
) (
  input  logic          rd_clk,
  input  logic          rd_reset,
  input  logic          cfg_enable,
  input  logic          fifo_empty,
  input  logic [AW:0]   fifo_aval,
  input  logic [W-1:0]  fifo_rd_data,
  output logic          fifo_rd_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_first,
  output logic          out_last,
  output logic [AW:0]   burst_len,
  output logic          burst_active,
  output logic          err_underrun
);
  localparam logic [AW:0] BL = (AW+1)'(BURST);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [TW-1:0] TMAX = TW'(TMO - 1);
  typedef enum logic [1:0] {IDLE, XFER, LAST} state_t;
  state_t state, state_nx;
  logic [TW-1:0] timer;
  logic [AW:0] rem, len;
  logic first_pend, pop, start_thr, start_tmo, start;
  always_comb begin
    start_thr = cfg_enable && fifo_aval >= BL;
    start_tmo = cfg_enable && timer == TMAX && fifo_aval != '0;
    start = state == IDLE && (start_thr || start_tmo);
    len = start_thr ? BL : fifo_aval;
    pop = !rd_reset && state == XFER && !fifo_empty && rem != '0 && (!out_valid || out_ready);
    state_nx = start ? XFER :
               (pop && rem == ONE) ? LAST :
               (state == LAST && out_valid && out_ready) ? IDLE : state;
  end
  assign fifo_rd_en = pop;
  assign burst_active = state != IDLE;
  always_ff @(posedge rd_clk) begin
    if (rd_reset) begin
      state <= IDLE;
      timer <= '0;
      rem <= '0;
      first_pend <= 1'b0;
      burst_len <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_first <= 1'b0;
      out_last <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      state <= state_nx;
      // idle timer only advances while a partial residue sits in the FIFO
      if (state == IDLE)
        timer <= (fifo_aval == '0 || !cfg_enable || start) ? '0 :
                 (fifo_aval < BL && timer != TMAX) ? timer + 1'b1 : timer;
      if (start) begin
        burst_len <= len;
        rem <= len;
        first_pend <= 1'b1;
      end
      if (pop) begin
        out_data <= fifo_rd_data;
        out_valid <= 1'b1;
        out_first <= first_pend;
        first_pend <= 1'b0;
        out_last <= rem == ONE;
        rem <= rem - ONE;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (state == XFER && fifo_empty && rem != '0)
        err_underrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_async_fifo_rd_burst.sv
// tb_async_fifo_rd_burst: FIFO model plus scoreboard bench for the burst drain controller
module tb_async_fifo_rd_burst;
  localparam int W = 8, DP = 8, BURST = 4, TMO = 16, TW = 5, AW = 3;
  logic rd_clk = 1'b0;
  logic rd_reset, cfg_enable, fifo_empty, fifo_rd_en, out_valid, out_ready;
  logic out_first, out_last, burst_active, err_underrun;
  logic [AW:0] fifo_aval, burst_len;
  logic [W-1:0] fifo_rd_data, out_data;
  typedef struct packed {logic [W-1:0] d; logic f; logic l;} exp_t;
  logic [W-1:0] fq[$];
  exp_t exp_q[$];
  int n_cmp = 0, n_bad = 0;
  logic s_en, s_valid, s_active, s_err;
  logic [W-1:0] s_data;
  logic [AW:0] s_len;

  async_fifo_rd_burst #(.W(W), .DP(DP), .BURST(BURST), .TMO(TMO), .TW(TW)) dut (
    .rd_clk(rd_clk), .rd_reset(rd_reset), .cfg_enable(cfg_enable),
    .fifo_empty(fifo_empty), .fifo_aval(fifo_aval), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_first(out_first), .out_last(out_last),
    .burst_len(burst_len), .burst_active(burst_active), .err_underrun(err_underrun)
  );

  always #5 rd_clk = ~rd_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic drive_fifo();
    fifo_empty = fq.size() == 0;
    fifo_aval = (AW+1)'(fq.size());
    fifo_rd_data = fq.size() != 0 ? fq[0] : '0;
  endtask

  task automatic load(input logic [W-1:0] base, input int n, input int b);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      fq.push_back(base + W'(i));
      e.d = base + W'(i);
      e.f = (i % b) == 0;
      e.l = (i % b) == b - 1 || i == n - 1;
      exp_q.push_back(e);
    end
    drive_fifo();
  endtask

  // one clock: sample at negedge, score handshakes, then advance the FIFO model
  task automatic tick();
    exp_t e;
    @(negedge rd_clk);
    s_en = fifo_rd_en;
    s_valid = out_valid;
    s_active = burst_active;
    s_err = err_underrun;
    s_data = out_data;
    s_len = burst_len;
    if (out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_extra: got word %h first %b last %b, required no word", out_data, out_first, out_last);
      end else begin
        e = exp_q.pop_front();
        if ({out_data, out_first, out_last} !== e) begin
          n_bad++;
          $display("FAIL sb_word: got %h/%b/%b, required %h/%b/%b", out_data, out_first, out_last, e.d, e.f, e.l);
        end
      end
    end
    @(posedge rd_clk);
    #1;
    if (s_en && fq.size() != 0) fq.delete(0);
    drive_fifo();
  endtask

  task automatic test_reset();
    rd_reset = 1'b1;
    cfg_enable = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) fq.push_back(W'(8'h55 + i));
    drive_fifo();
    repeat (3) tick();
    n_cmp++;
    if ({s_en, s_valid, s_active, s_err} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got en/valid/active/err %b%b%b%b, required 0000", s_en, s_valid, s_active, s_err);
    end
    n_cmp++;
    if (s_len !== '0 || s_data !== '0) begin
      n_bad++;
      $display("FAIL reset_regs: got len %0d data %h, required 0/00", s_len, s_data);
    end
    fq.delete();
    drive_fifo();
    rd_reset = 1'b0;
    tick();
  endtask

  task automatic test_threshold();
    logic [5:0] en_b, val_b;
    load(8'hA0, 4, 4);
    for (int i = 0; i < 6; i++) begin
      tick();
      en_b[i] = s_en;
      val_b[i] = s_valid;
    end
    n_cmp++;
    if (en_b !== 6'b011110) begin
      n_bad++;
      $display("FAIL thr_rd_en: got pattern %b, required 011110", en_b);
    end
    n_cmp++;
    if (val_b !== 6'b111100) begin
      n_bad++;
      $display("FAIL thr_valid: got pattern %b, required 111100", val_b);
    end
    repeat (2) tick();
    n_cmp++;
    if (s_len !== 4'd4 || s_active !== 1'b0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL thr_done: got len %0d active %b pending %0d, required 4/0/0", s_len, s_active, exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int k;
    load(8'hB0, 2, 2);
    for (k = 0; k < 40; k++) begin
      tick();
      if (s_en) break;
    end
    n_cmp++;
    if (k != 16) begin
      n_bad++;
      $display("FAIL tmo_start: got first pop at cycle %0d, required 16", k);
    end
    repeat (4) tick();
    n_cmp++;
    if (s_len !== 4'd2 || exp_q.size() != 0 || fq.size() != 0) begin
      n_bad++;
      $display("FAIL tmo_done: got len %0d pending %0d fifo %0d, required 2/0/0", s_len, exp_q.size(), fq.size());
    end
  endtask

  task automatic test_stall();
    int k;
    load(8'hC0, 4, 4);
    for (k = 0; k < 10; k++) begin
      tick();
      if (s_valid) break;
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (s_en !== 1'b0 || s_valid !== 1'b1 || s_data !== 8'hC1) begin
        n_bad++;
        $display("FAIL stall_hold%0d: got en %b valid %b data %h, required 0/1/c1", i, s_en, s_valid, s_data);
      end
    end
    out_ready = 1'b1;
    repeat (6) tick();
    n_cmp++;
    if (exp_q.size() != 0 || fq.size() != 0) begin
      n_bad++;
      $display("FAIL stall_done: got pending %0d fifo %0d, required 0/0", exp_q.size(), fq.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] en_b, act_b;
    load(8'hD0, 8, 4);
    for (int i = 0; i < 13; i++) begin
      tick();
      en_b[i] = s_en;
      act_b[i] = s_active;
    end
    n_cmp++;
    if (act_b !== 13'b0111110111110) begin
      n_bad++;
      $display("FAIL b2b_active: got %b, required 0111110111110", act_b);
    end
    n_cmp++;
    if (en_b !== 13'b0011110011110) begin
      n_bad++;
      $display("FAIL b2b_rd_en: got %b, required 0011110011110", en_b);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_done: got pending %0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_enable();
    int k, pops;
    cfg_enable = 1'b0;
    load(8'hE0, 4, 4);
    pops = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      pops += int'(s_en) + int'(s_active);
    end
    n_cmp++;
    if (pops != 0) begin
      n_bad++;
      $display("FAIL en_off: got %0d pop/active cycles, required 0", pops);
    end
    cfg_enable = 1'b1;
    for (k = 0; k < 10; k++) begin
      tick();
      if (s_en) break;
    end
    cfg_enable = 1'b0;
    n_cmp++;
    if (k != 1) begin
      n_bad++;
      $display("FAIL en_start: got first pop at cycle %0d, required 1", k);
    end
    repeat (6) tick();
    n_cmp++;
    if (exp_q.size() != 0 || s_active !== 1'b0) begin
      n_bad++;
      $display("FAIL en_drop: got pending %0d active %b, required 0/0", exp_q.size(), s_active);
    end
    load(8'hE8, 2, 2);
    repeat (20) tick();
    cfg_enable = 1'b1;
    for (k = 0; k < 40; k++) begin
      tick();
      if (s_en) break;
    end
    n_cmp++;
    if (k != 16) begin
      n_bad++;
      $display("FAIL en_timer: got first pop at cycle %0d, required 16", k);
    end
    repeat (4) tick();
  endtask

  task automatic test_underrun();
    int k;
    load(8'hF0, 4, 4);
    for (k = 0; k < 5; k++) begin
      tick();
      if (s_en) break;
    end
    fq.delete();
    drive_fifo();
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    repeat (3) tick();
    n_cmp++;
    if (s_err !== 1'b1 || s_active !== 1'b1 || s_en !== 1'b0) begin
      n_bad++;
      $display("FAIL underrun: got err %b active %b en %b, required 1/1/0", s_err, s_active, s_en);
    end
    rd_reset = 1'b1;
    repeat (2) tick();
    rd_reset = 1'b0;
    n_cmp++;
    if (s_err !== 1'b0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL underrun_clr: got err %b pending %0d, required 0/0", s_err, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int k, pops;
    load(8'h90, 4, 4);
    pops = 0;
    for (k = 0; k < 10 && pops < 2; k++) begin
      tick();
      pops += int'(s_en);
    end
    rd_reset = 1'b1;
    tick();
    n_cmp++;
    if (s_en !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_en: got rd_en %b during reset, required 0", s_en);
    end
    tick();
    n_cmp++;
    if ({s_valid, s_active, s_err} !== 3'b0 || s_len !== '0) begin
      n_bad++;
      $display("FAIL rst_mid: got valid/active/err %b%b%b len %0d, required 000/0", s_valid, s_active, s_err, s_len);
    end
    fq.delete();
    exp_q.delete();
    drive_fifo();
    rd_reset = 1'b0;
    pops = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      pops += int'(s_en);
    end
    n_cmp++;
    if (pops != 0) begin
      n_bad++;
      $display("FAIL rst_after: got %0d pops after reset, required 0", pops);
    end
  endtask

  initial begin
    rd_reset = 1'b1;
    cfg_enable = 1'b0;
    out_ready = 1'b1;
    drive_fifo();
    test_reset();
    test_threshold();
    test_timeout();
    test_stall();
    test_back_to_back();
    test_enable();
    cfg_enable = 1'b1;
    test_underrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
